// File: rtl/mux_stream_rr.sv
// N-channel registered stream mux, round-robin or fixed select.
// Optional packet lock: define MUX_STREAM_PKT_LOCK_EN.
module mux_stream_rr #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]  in_ready,
  input  logic          mode,
  input  logic [SW-1:0] sel,
`ifdef MUX_STREAM_PKT_LOCK_EN
  input  logic [N-1:0]  in_last,
  output logic          out_last,
`endif
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [SW-1:0] out_ch,
  input  logic          out_ready
);

  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_ch;
  logic [SW-1:0] r_ptr;

  logic          w_load;
  logic          w_xfer;
  logic          w_rr_v;
  logic [SW-1:0] w_rr_gnt;
  logic          w_fix_v;
  logic          w_gnt_v;
  logic [SW-1:0] w_gnt;
  logic [W-1:0]  w_data;

`ifdef MUX_STREAM_PKT_LOCK_EN
  logic          r_lock;
  logic [SW-1:0] r_lock_ch;
  logic          r_out_last;
  logic          w_lock_v;
  logic          w_last;
`endif

  assign w_load = !r_out_valid || out_ready;
  assign w_xfer = rst_n && w_load && w_gnt_v;

  // Round-robin: first valid above ptr, else first valid at/below ptr
  always_comb begin
    w_rr_v   = 1'b0;
    w_rr_gnt = '0;
    for (int i = 0; i < N; i++) begin
      if (!w_rr_v && in_valid[i] && i > int'(r_ptr)) begin
        w_rr_v   = 1'b1;
        w_rr_gnt = SW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_rr_v && in_valid[i] && i <= int'(r_ptr)) begin
        w_rr_v   = 1'b1;
        w_rr_gnt = SW'(i);
      end
    end
  end

  // Fixed select; an index >= N matches no channel and never grants
  always_comb begin
    w_fix_v = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i)) begin
        w_fix_v = in_valid[i];
      end
    end
  end

`ifdef MUX_STREAM_PKT_LOCK_EN
  // Valid of the locked channel
  always_comb begin
    w_lock_v = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (r_lock_ch == SW'(i)) begin
        w_lock_v = in_valid[i];
      end
    end
  end

  // Grant: an open packet overrides mode and sel
  always_comb begin
    w_gnt   = w_rr_gnt;
    w_gnt_v = w_rr_v;
    if (r_lock) begin
      w_gnt   = r_lock_ch;
      w_gnt_v = w_lock_v;
    end else if (mode) begin
      w_gnt   = sel;
      w_gnt_v = w_fix_v;
    end
  end
`else
  // Grant: fixed select or round-robin
  always_comb begin
    w_gnt   = w_rr_gnt;
    w_gnt_v = w_rr_v;
    if (mode) begin
      w_gnt   = sel;
      w_gnt_v = w_fix_v;
    end
  end
`endif

  // One-hot ready and data/last mux of the granted channel
  always_comb begin
    in_ready = '0;
    w_data   = '0;
`ifdef MUX_STREAM_PKT_LOCK_EN
    w_last   = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      if (w_gnt == SW'(i)) begin
        in_ready[i] = w_xfer;
        w_data      = in_data[i*W +: W];
`ifdef MUX_STREAM_PKT_LOCK_EN
        w_last      = in_last[i];
`endif
      end
    end
  end

  // Output register: load on transfer, drop valid on plain drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= SW'(N - 1);
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_ch    <= w_gnt;
      r_ptr       <= w_gnt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef MUX_STREAM_PKT_LOCK_EN
  // Packet lock and registered last flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock     <= 1'b0;
      r_lock_ch  <= '0;
      r_out_last <= 1'b0;
    end else if (w_xfer) begin
      r_lock     <= !w_last;
      r_lock_ch  <= w_gnt;
      r_out_last <= w_last;
    end
  end

  assign out_last = r_out_last;
`endif

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

endmodule
